// File: rtl/program_sequencer_pkg.sv
// Shared defaults and the next-address source encoding for the program sequencer.
package program_sequencer_pkg;

    localparam int ADDR_W_DEF      = 8;
    localparam int PAGE_W_DEF      = 4;
    localparam int STACK_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        NXT_RESET,
        NXT_HOLD,
        NXT_JMP,
        NXT_CALL,
        NXT_RET,
        NXT_COND,
        NXT_INC,
        NXT_ERR_INC
    } nxt_sel_t;

endpackage

// File: rtl/program_sequencer_stack_return_stack.sv
// Return-address LIFO: writes land on the edge after push, top/full/empty decode registered state.
// Contents survive reset; only the pointer is cleared. Push when full / pop when empty are ignored.
module return_stack #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int SP_W  = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            sync_reset,
    input  logic            push,
    input  logic            pop,
    input  logic [W-1:0]    din,
    output logic [W-1:0]    top,
    output logic            full,
    output logic            empty,
    output logic [SP_W-1:0] sp
);

    logic [W-1:0] mem [DEPTH];

    assign full  = (sp == SP_W'(DEPTH));
    assign empty = (sp == '0);

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sp <= '0;
        end else if (push && !full) begin
            sp <= sp + SP_W'(1);
        end else if (pop && !empty) begin
            sp <= sp - SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!sync_reset && push && !full && sp == SP_W'(i)) begin
                mem[i] <= din;
            end
        end
    end

    // Entry below the pointer; reads as zero when nothing has been pushed.
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sp == SP_W'(i + 1)) begin
                top = mem[i];
            end
        end
    end

endmodule

// File: rtl/program_sequencer_stack.sv
// Program sequencer: priority-selected next address (combinational pm_addr), registered pc,
// hardware return stack and a sticky overflow/underflow flag cleared only by reset.
module program_sequencer_stack
    import program_sequencer_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int PAGE_W      = PAGE_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     sync_reset,
    input  logic                     hold,
    input  logic                     jmp,
    input  logic                     jmp_nz,
    input  logic                     dont_jmp,
    input  logic                     call,
    input  logic                     ret,
    input  logic [ADDR_W-PAGE_W-1:0] jmp_addr,
    output logic [ADDR_W-1:0]        pm_addr,
    output logic [ADDR_W-1:0]        pc,
    output logic [ADDR_W-1:0]        from_PS,
    output logic                     stack_full,
    output logic                     stack_empty,
    output logic                     stack_err
);

    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    nxt_sel_t           nxt_sel;
    logic [ADDR_W-1:0]  pc_inc;
    logic [ADDR_W-1:0]  target;
    logic [SP_W-1:0]    sp;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    assign pc_inc = pc + ADDR_W'(1);
    assign target = {jmp_addr, {PAGE_W{1'b0}}};

    // Lower-priority requests in the same cycle are dropped entirely.
    always_comb begin
        nxt_sel = NXT_INC;
        if (sync_reset) begin
            nxt_sel = NXT_RESET;
        end else if (hold) begin
            nxt_sel = NXT_HOLD;
        end else if (jmp) begin
            nxt_sel = NXT_JMP;
        end else if (call) begin
            nxt_sel = full ? NXT_ERR_INC : NXT_CALL;
        end else if (ret) begin
            nxt_sel = empty ? NXT_ERR_INC : NXT_RET;
        end else if (jmp_nz && !dont_jmp) begin
            nxt_sel = NXT_COND;
        end
    end

    always_comb begin
        pm_addr = pc_inc;
        unique case (nxt_sel)
            NXT_RESET: pm_addr = '0;
            NXT_HOLD:  pm_addr = pc;
            NXT_JMP,
            NXT_CALL,
            NXT_COND:  pm_addr = target;
            NXT_RET:   pm_addr = from_PS;
            default:   pm_addr = pc_inc;
        endcase
    end

    assign push = (nxt_sel == NXT_CALL);
    assign pop  = (nxt_sel == NXT_RET);

    always_ff @(posedge clk) begin
        pc <= pm_addr;
        if (sync_reset) begin
            stack_err <= 1'b0;
        end else if (nxt_sel == NXT_ERR_INC) begin
            stack_err <= 1'b1;
        end
    end

    return_stack #(
        .W     (ADDR_W),
        .DEPTH (STACK_DEPTH),
        .SP_W  (SP_W)
    ) u_stack (
        .clk        (clk),
        .sync_reset (sync_reset),
        .push       (push),
        .pop        (pop),
        .din        (pc_inc),
        .top        (from_PS),
        .full       (full),
        .empty      (empty),
        .sp         (sp)
    );

    assign stack_full  = full;
    assign stack_empty = (sp == '0);

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Directed vector bench for program_sequencer_stack at default parameters.
module tb_program_sequencer_stack;

    logic       clk = 1'b0;
    logic       sync_reset;
    logic       hold, jmp, jmp_nz, dont_jmp, call, ret;
    logic [3:0] jmp_addr;
    logic [7:0] pm_addr, pc, from_PS;
    logic       stack_full, stack_empty, stack_err;

    int total_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    program_sequencer_stack dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .hold        (hold),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .dont_jmp    (dont_jmp),
        .call        (call),
        .ret         (ret),
        .jmp_addr    (jmp_addr),
        .pm_addr     (pm_addr),
        .pc          (pc),
        .from_PS     (from_PS),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    // ctl bits: {hold, jmp, jmp_nz, dont_jmp, call, ret}
    localparam logic [5:0] IDLE = 6'b000000;
    localparam logic [5:0] HOLD = 6'b100000;
    localparam logic [5:0] JMP  = 6'b010000;
    localparam logic [5:0] JNZ  = 6'b001000;
    localparam logic [5:0] DJ   = 6'b000100;
    localparam logic [5:0] CALL = 6'b000010;
    localparam logic [5:0] RET  = 6'b000001;

    typedef struct {
        logic [5:0] ctl;
        logic [3:0] ja;
        logic [7:0] pm;    // expected pm_addr before the edge, pc after it
        logic [7:0] top;   // expected from_PS after the edge
        logic [2:0] flg;   // expected {stack_full, stack_empty, stack_err} after the edge
    } vec_t;

    vec_t vecs [35];

    function automatic vec_t mk(input logic [5:0] ctl, input logic [3:0] ja,
                                input logic [7:0] pm, input logic [7:0] top,
                                input logic [2:0] flg);
        vec_t r;
        r.ctl = ctl; r.ja = ja; r.pm = pm; r.top = top; r.flg = flg;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        sync_reset = 1'b0;
        {hold, jmp, jmp_nz, dont_jmp, call, ret} = v.ctl;
        jmp_addr = v.ja;
        #1;
        chk("pm_addr", idx, pm_addr, v.pm);
        @(posedge clk);
        #1;
        chk("pc", idx, pc, v.pm);
        chk("from_PS", idx, from_PS, v.top);
        chk("flags", idx, {stack_full, stack_empty, stack_err}, v.flg);
    endtask

    initial begin
        vecs[0]  = mk(IDLE,           4'h0, 8'h01, 8'h00, 3'b010);
        vecs[1]  = mk(IDLE,           4'h0, 8'h02, 8'h00, 3'b010);
        vecs[2]  = mk(IDLE,           4'h0, 8'h03, 8'h00, 3'b010);
        vecs[3]  = mk(JMP,            4'hA, 8'hA0, 8'h00, 3'b010);
        vecs[4]  = mk(JMP,            4'h1, 8'h10, 8'h00, 3'b010);
        vecs[5]  = mk(JNZ | DJ,       4'hA, 8'h11, 8'h00, 3'b010);
        vecs[6]  = mk(JMP,            4'h1, 8'h10, 8'h00, 3'b010);
        vecs[7]  = mk(JNZ,            4'hA, 8'hA0, 8'h00, 3'b010);
        vecs[8]  = mk(JMP,            4'h0, 8'h00, 8'h00, 3'b010);
        vecs[9]  = mk(IDLE,           4'h0, 8'h01, 8'h00, 3'b010);
        vecs[10] = mk(IDLE,           4'h0, 8'h02, 8'h00, 3'b010);
        vecs[11] = mk(IDLE,           4'h0, 8'h03, 8'h00, 3'b010);
        vecs[12] = mk(IDLE,           4'h0, 8'h04, 8'h00, 3'b010);
        vecs[13] = mk(IDLE,           4'h0, 8'h05, 8'h00, 3'b010);
        vecs[14] = mk(CALL,           4'h3, 8'h30, 8'h06, 3'b000);
        vecs[15] = mk(IDLE,           4'h0, 8'h31, 8'h06, 3'b000);
        vecs[16] = mk(RET,            4'h0, 8'h06, 8'h00, 3'b010);
        vecs[17] = mk(CALL,           4'h1, 8'h10, 8'h07, 3'b000);
        vecs[18] = mk(CALL,           4'h2, 8'h20, 8'h11, 3'b000);
        vecs[19] = mk(CALL,           4'h3, 8'h30, 8'h21, 3'b000);
        vecs[20] = mk(CALL,           4'h4, 8'h40, 8'h31, 3'b100);
        vecs[21] = mk(CALL,           4'h5, 8'h41, 8'h31, 3'b101);
        vecs[22] = mk(RET,            4'h0, 8'h31, 8'h21, 3'b001);
        vecs[23] = mk(RET,            4'h0, 8'h21, 8'h11, 3'b001);
        vecs[24] = mk(RET,            4'h0, 8'h11, 8'h07, 3'b001);
        vecs[25] = mk(RET,            4'h0, 8'h07, 8'h00, 3'b011);
        vecs[26] = mk(RET,            4'h0, 8'h08, 8'h00, 3'b011);
        vecs[27] = mk(CALL,           4'h6, 8'h60, 8'h09, 3'b001);
        vecs[28] = mk(JMP|CALL|RET,   4'h7, 8'h70, 8'h09, 3'b001);
        vecs[29] = mk(CALL | RET,     4'h8, 8'h80, 8'h71, 3'b001);
        vecs[30] = mk(RET | JNZ,      4'h9, 8'h71, 8'h09, 3'b001);
        vecs[31] = mk(HOLD | CALL,    4'h2, 8'h71, 8'h09, 3'b001);
        vecs[32] = mk(HOLD | CALL,    4'h2, 8'h71, 8'h09, 3'b001);
        vecs[33] = mk(HOLD | CALL,    4'h2, 8'h71, 8'h09, 3'b001);
        vecs[34] = mk(RET,            4'h0, 8'h09, 8'h00, 3'b011);

        // Reset held for two edges.
        sync_reset = 1'b1;
        {hold, jmp, jmp_nz, dont_jmp, call, ret} = IDLE;
        jmp_addr = 4'h0;
        #1;
        chk("rst_pm_addr", 0, pm_addr, 8'h00);
        @(posedge clk);
        @(negedge clk);
        chk("rst_pm_addr", 1, pm_addr, 8'h00);
        @(posedge clk);
        #1;
        chk("rst_pc", 0, pc, 8'h00);
        chk("rst_from_PS", 0, from_PS, 8'h00);
        chk("rst_flags", 0, {stack_full, stack_empty, stack_err}, 3'b010);

        for (int i = 0; i < 35; i++) begin
            apply(vecs[i], i);
        end

        // Address wrap FF -> 00.
        apply(mk(JMP, 4'hF, 8'hF0, 8'h00, 3'b011), 100);
        for (int i = 1; i <= 16; i++) begin
            logic [7:0] e;
            e = 8'hF0 + 8'(i);
            apply(mk(IDLE, 4'h0, e, 8'h00, 3'b011), 100 + i);
        end

        // Reset arriving together with a call while the stack holds an entry.
        apply(mk(CALL, 4'h3, 8'h30, 8'h01, 3'b001), 200);
        @(negedge clk);
        sync_reset = 1'b1;
        {hold, jmp, jmp_nz, dont_jmp, call, ret} = CALL;
        jmp_addr = 4'h5;
        #1;
        chk("rstcall_pm_addr", 0, pm_addr, 8'h00);
        @(posedge clk);
        #1;
        chk("rstcall_pc", 0, pc, 8'h00);
        chk("rstcall_from_PS", 0, from_PS, 8'h00);
        chk("rstcall_flags", 0, {stack_full, stack_empty, stack_err}, 3'b010);
        // Stack really empty: a ret underflows.
        apply(mk(RET, 4'h0, 8'h01, 8'h00, 3'b011), 201);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
